uart_bus_loader: RTL and testbench

//  Bus master that streams a program image from the UART receive byte path into SRAM

---
 rtl/uart_bus_loader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_bus_loader.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_loader.sv
// -----------------------------------------------------------------------------
// uart_bus_loader
//
// Bus master that streams a program image arriving on the UART receive byte
// path into SRAM over the shared system bus (master slot 5 of the bus
// controller).
//
// Frame on the byte stream:
//   len[7:0], len[15:8], then len words of 4 bytes each, little-endian.
// Each assembled word becomes one write transaction: an address phase
// (CMD_WRITE + byte address), a data phase (CMD_DATA + word), then a wait for
// CMD_DONE from the RAM device. The address starts at BASE_ADDR and steps by 4.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high
//   start          one-cycle pulse, arms the loader when idle
//   rx_data        received UART byte
//   rx_valid       rx_data valid this cycle
//   rx_ready       loader accepts a byte this cycle
//   bus_req        request to the bus controller
//   bus_ack        grant; the bus is owned while high
//   ctrl_in        shared bus control (CMD_DONE from RAM ends a write)
//   bus_out        address/data, driven only while granted, else 0
//   ctrl_out       command, driven only while granted, else 0
//   busy           armed and frame not finished
//   done           sticky, frame fully written
//   error          sticky, timeout / lost grant / receive overflow
//   words_written  completed write count
// -----------------------------------------------------------------------------
module uart_bus_loader #(
  parameter int                   D_WIDTH   = 32,
  parameter int                   C_WIDTH   = 8,
  parameter int                   LEN_WIDTH = 16,
  parameter logic [D_WIDTH-1:0]   BASE_ADDR = 32'h0,
  parameter logic [C_WIDTH-1:0]   CMD_WRITE = 8'h10,
  parameter logic [C_WIDTH-1:0]   CMD_DATA  = 8'h11,
  parameter logic [C_WIDTH-1:0]   CMD_DONE  = 8'h12,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 bus_req,
  input  logic                 bus_ack,
  input  logic [C_WIDTH-1:0]   ctrl_in,
  output logic [D_WIDTH-1:0]   bus_out,
  output logic [C_WIDTH-1:0]   ctrl_out,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_written
);

  // Assembly register holds the first three bytes of a word; the fourth byte
  // goes straight into the holding register together with them.
  localparam int ASM_W = D_WIDTH - 8;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_LEN0,
    RX_LEN1,
    RX_COLLECT,
    RX_FINISH
  } rx_state_t;

  typedef enum logic [2:0] {
    B_IDLE,
    B_REQ,
    B_ADDR,
    B_DATA,
    B_WAIT
  } bus_state_t;

  rx_state_t  rx_state, rx_next;
  bus_state_t b_state,  b_next;

  logic [7:0]           len_lo;
  logic [LEN_WIDTH-1:0] length;
  logic [LEN_WIDTH-1:0] length_in;
  logic [LEN_WIDTH-1:0] words_received;
  logic [ASM_W-1:0]     asm_reg;
  logic [1:0]           asm_cnt;
  logic [D_WIDTH-1:0]   hold_reg;
  logic                 hold_full;
  logic [D_WIDTH-1:0]   addr;
  logic [TW-1:0]        wait_cnt;

  logic armed_rx;
  logic collecting;
  logic byte_take;
  logic overflow;
  logic word_push;
  logic write_done;
  logic bus_fail;
  logic granted_phase;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign length_in     = LEN_WIDTH'({rx_data, len_lo});
  assign armed_rx      = rx_state inside {RX_LEN0, RX_LEN1, RX_COLLECT};
  assign collecting    = (rx_state == RX_COLLECT) && (words_received != length);
  assign granted_phase = b_state inside {B_ADDR, B_DATA, B_WAIT};

  // A write completes only while the grant is still held.
  assign write_done = (b_state == B_WAIT) && bus_ack && (ctrl_in == CMD_DONE);

  // Losing the grant in any owned phase, or sitting in B_WAIT for TIMEOUT
  // cycles without CMD_DONE, aborts the whole load.
  assign bus_fail = granted_phase &&
                    (!bus_ack ||
                     ((b_state == B_WAIT) && (ctrl_in != CMD_DONE) &&
                      (wait_cnt == WAIT_LAST)));

  // Backpressure only when a 4th byte would have nowhere to go. A completing
  // write frees the holding register in the same cycle, so it can refill.
  assign rx_ready  = armed_rx &&
                     !((asm_cnt == 2'd3) && hold_full && !write_done);
  assign byte_take = rx_valid && rx_ready;
  assign overflow  = rx_valid && armed_rx && !rx_ready;
  assign word_push = byte_take && collecting && (asm_cnt == 2'd3);

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin : rx_next_logic
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:    if (start) rx_next = RX_LEN0;
      RX_LEN0:    if (byte_take) rx_next = RX_LEN1;
      RX_LEN1:    if (byte_take) rx_next = (length_in == '0) ? RX_FINISH : RX_COLLECT;
      RX_COLLECT: if (words_written == length) rx_next = RX_FINISH;
      RX_FINISH:  if (words_written == length) rx_next = RX_IDLE;
      default:    rx_next = RX_IDLE;
    endcase
    if (bus_fail) rx_next = RX_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Bus state machine
  // ---------------------------------------------------------------------------
  always_comb begin : bus_next_logic
    b_next = b_state;
    unique case (b_state)
      B_IDLE:  if (hold_full) b_next = B_REQ;
      B_REQ:   if (bus_ack) b_next = B_ADDR;
      B_ADDR:  b_next = B_DATA;
      B_DATA:  b_next = B_WAIT;
      B_WAIT:  if (write_done) b_next = B_IDLE;
      default: b_next = B_IDLE;
    endcase
    if (bus_fail) b_next = B_IDLE;
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order. Later
  // assignments in this block deliberately override earlier ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state       <= RX_IDLE;
      b_state        <= B_IDLE;
      len_lo         <= '0;
      length         <= '0;
      words_received <= '0;
      words_written  <= '0;
      asm_reg        <= '0;
      asm_cnt        <= '0;
      hold_reg       <= '0;
      hold_full      <= 1'b0;
      addr           <= BASE_ADDR;
      wait_cnt       <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      rx_state <= rx_next;
      b_state  <= b_next;

      if (b_state == B_WAIT) wait_cnt <= wait_cnt + TW'(1);
      else                   wait_cnt <= '0;

      // Arming a new frame; start is ignored outside RX_IDLE.
      if ((rx_state == RX_IDLE) && start) begin
        done           <= 1'b0;
        error          <= 1'b0;
        words_written  <= '0;
        words_received <= '0;
        asm_cnt        <= '0;
        hold_full      <= 1'b0;
        addr           <= BASE_ADDR;
      end

      if (byte_take && (rx_state == RX_LEN0)) len_lo <= rx_data;
      if (byte_take && (rx_state == RX_LEN1)) length <= length_in;

      // Little-endian assembly: bytes enter at the top and shift down, so the
      // first byte of a word ends up in bits [7:0].
      if (byte_take && collecting) begin
        if (asm_cnt == 2'd3) begin
          hold_reg       <= {rx_data, asm_reg};
          asm_cnt        <= '0;
          words_received <= words_received + LEN_WIDTH'(1);
        end else begin
          asm_reg <= {rx_data, asm_reg[ASM_W-1:8]};
          asm_cnt <= asm_cnt + 2'd1;
        end
      end

      if (write_done) begin
        addr          <= addr + D_WIDTH'(4);
        words_written <= words_written + LEN_WIDTH'(1);
      end

      if (word_push)       hold_full <= 1'b1;
      else if (write_done) hold_full <= 1'b0;

      if (overflow) error <= 1'b1;

      if ((rx_state == RX_FINISH) && (words_written == length)) done <= 1'b1;

      // Abort drops any partially loaded data; there is no retry.
      if (bus_fail) begin
        error     <= 1'b1;
        hold_full <= 1'b0;
        asm_cnt   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (rx_state != RX_IDLE);

  always_comb begin : bus_drive
    bus_req  = (b_state != B_IDLE);
    bus_out  = '0;
    ctrl_out = '0;
    // Shared bus lines are only driven while this master holds the grant.
    if (bus_ack) begin
      unique case (b_state)
        B_ADDR: begin
          ctrl_out = CMD_WRITE;
          bus_out  = addr;
        end
        B_DATA: begin
          ctrl_out = CMD_DATA;
          bus_out  = hold_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_loader
//
// Directed bench for uart_bus_loader. Byte stimulus is driven on the falling
// edge (sampled by the DUT on the next rising edge); the bus responder drives
// bus_ack/ctrl_in just after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_bus_loader;

  localparam logic [7:0] CMD_WRITE = 8'h10;
  localparam logic [7:0] CMD_DATA  = 8'h11;
  localparam logic [7:0] CMD_DONE  = 8'h12;
  localparam int         TIMEOUT   = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        bus_req;
  logic        bus_ack = 1'b0;
  logic [7:0]  ctrl_in = 8'h00;
  logic [31:0] bus_out;
  logic [7:0]  ctrl_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_addr [0:3];
  logic [31:0] got_data [0:3];
  int          got_n = 0;
  int          req_total = 0;

  always #20 clk = ~clk;

  always @(negedge clk) if (bus_req) req_total++;

  uart_bus_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .bus_req       (bus_req),
    .bus_ack       (bus_ack),
    .ctrl_in       (ctrl_in),
    .bus_out       (bus_out),
    .ctrl_out      (ctrl_out),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    bus_ack  = 1'b0;
    ctrl_in  = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_byte_ready: rx_ready=%b, required 1 within 100 cycles", rx_ready);
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk) #1 rx_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  // Plays the bus controller and RAM for n writes, recording each address and
  // data phase into got_addr/got_data.
  task automatic serve_words(input int n, input int ack_dly, input int done_dly);
    for (int w = 0; w < n; w++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (!bus_req && t < 300) begin
        t++;
        @(negedge clk);
      end
      checks++;
      if (bus_req !== 1'b1) begin
        errors++;
        $display("FAIL serve_req word %0d: bus_req=%b, required 1", w, bus_req);
        return;
      end
      repeat (ack_dly) @(posedge clk);
      #1 bus_ack = 1'b1;
      t = 0;
      @(negedge clk);
      while (ctrl_out !== CMD_WRITE && t < 10) begin
        t++;
        @(negedge clk);
      end
      checks++;
      if (ctrl_out !== CMD_WRITE) begin
        errors++;
        $display("FAIL serve_addr_phase word %0d: ctrl_out=%h, required %h", w, ctrl_out, CMD_WRITE);
      end
      got_addr[got_n] = bus_out;
      @(negedge clk);
      checks++;
      if (ctrl_out !== CMD_DATA) begin
        errors++;
        $display("FAIL serve_data_phase word %0d: ctrl_out=%h, required %h", w, ctrl_out, CMD_DATA);
      end
      got_data[got_n] = bus_out;
      got_n++;
      repeat (done_dly) @(posedge clk);
      #1 ctrl_in = CMD_DONE;
      @(posedge clk) #1;
      ctrl_in = 8'h00;
      bus_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b0) begin
        errors++;
        $display("FAIL serve_req_release word %0d: bus_req=%b, required 0", w, bus_req);
      end
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 50) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b, required 1 within 50 cycles", done);
    end
  endtask

  task automatic wait_req_then_data();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus_req && t < 50) begin
      t++;
      @(negedge clk);
    end
    #1 bus_ack = 1'b1;
    t = 0;
    @(negedge clk);
    while (ctrl_out !== CMD_DATA && t < 10) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (ctrl_out !== CMD_DATA) begin
      errors++;
      $display("FAIL reach_data_phase: ctrl_out=%h, required %h", ctrl_out, CMD_DATA);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus_req, busy, done, error, rx_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: req/busy/done/error/rx_ready=%b, required 00000",
               {bus_req, busy, done, error, rx_ready});
    end
    checks++;
    if ({bus_out, ctrl_out, words_written} !== 56'h0) begin
      errors++;
      $display("FAIL reset_bus: bus_out=%h ctrl_out=%h words_written=%0d, required 0 0 0",
               bus_out, ctrl_out, words_written);
    end
  endtask

  task automatic test_single(input logic [31:0] w);
    got_n = 0;
    pulse_start();
    fork
      begin
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(w);
        send_byte(8'h99);  // trailing byte beyond the frame
      end
      serve_words(1, 0, 1);
    join
    checks++;
    if (got_addr[0] !== 32'h0) begin
      errors++;
      $display("FAIL single_addr: got %h, required %h", got_addr[0], 32'h0);
    end
    checks++;
    if (got_data[0] !== w) begin
      errors++;
      $display("FAIL single_data: got %h, required %h", got_data[0], w);
    end
    wait_done();
    checks++;
    if ({busy, error, rx_ready} !== 3'b000 || words_written !== 16'd1) begin
      errors++;
      $display("FAIL single_end: busy/error/rx_ready=%b words_written=%0d, required 000 1",
               {busy, error, rx_ready}, words_written);
    end
  endtask

  task automatic test_multi();
    logic [31:0] exp_data [0:2];
    exp_data[0] = 32'hA0A1A2A3;
    exp_data[1] = 32'hDEADBEEF;
    exp_data[2] = 32'h00C0FFEE;
    got_n = 0;
    pulse_start();
    fork
      begin
        send_byte(8'h03);
        send_byte(8'h00);
        pulse_start();  // must be ignored while busy
        for (int i = 0; i < 3; i++) send_word(exp_data[i]);
      end
      serve_words(3, 5, 2);
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_addr[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL multi_addr[%0d]: got %h, required %h", i, got_addr[i], 32'(i * 4));
      end
      checks++;
      if (got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL multi_data[%0d]: got %h, required %h", i, got_data[i], exp_data[i]);
      end
    end
    checks++;
    if (words_written !== 16'd3 || done !== 1'b0) begin
      errors++;
      $display("FAIL multi_after_last: words_written=%0d done=%b, required 3 0", words_written, done);
    end
    wait_done();
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_end: error=%b busy=%b, required 0 0", error, busy);
    end
  endtask

  task automatic test_zero_len();
    int r0;
    r0 = req_total;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_cycle1: done=%b busy=%b, required 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || words_written !== 16'd0) begin
      errors++;
      $display("FAIL zero_len_cycle2: done=%b busy=%b words_written=%0d, required 1 0 0",
               done, busy, words_written);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_total !== r0) begin
      errors++;
      $display("FAIL zero_len_no_req: bus_req cycles=%0d, required 0", req_total - r0);
    end
  endtask

  task automatic test_timeout();
    int n;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h11223344);
    wait_req_then_data();
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1 || ctrl_out !== 8'h00 || bus_out !== 32'h0) begin
      errors++;
      $display("FAIL wait_outputs: bus_req=%b ctrl_out=%h bus_out=%h, required 1 00 0",
               bus_req, ctrl_out, bus_out);
    end
    n = 0;
    while (!error && n < 400) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycles: error after %0d wait cycles, required %0d", n, TIMEOUT);
    end
    checks++;
    if (error !== 1'b1 || bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: error=%b bus_req=%b busy=%b done=%b, required 1 0 0 0",
               error, bus_req, busy, done);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_overflow();
    got_n = 0;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL overflow_ready_byte6: rx_ready=%b, required 1", rx_ready);
    end
    send_byte(8'h07);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL overflow_ready_byte7: rx_ready=%b error=%b, required 0 0", rx_ready, error);
    end
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    @(posedge clk) #1 rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b1 || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: error=%b busy=%b bus_req=%b, required 1 1 1", error, busy, bus_req);
    end
    // Loading continues after the dropped byte.
    serve_words(1, 0, 1);
    fork
      send_byte(8'h08);
      serve_words(1, 0, 1);
    join
    checks++;
    if (got_data[0] !== 32'h04030201 || got_data[1] !== 32'h08070605 || got_addr[1] !== 32'h4) begin
      errors++;
      $display("FAIL overflow_continue: data0=%h data1=%h addr1=%h, required 04030201 08070605 00000004",
               got_data[0], got_data[1], got_addr[1]);
    end
    wait_done();
    checks++;
    if (error !== 1'b1 || words_written !== 16'd2) begin
      errors++;
      $display("FAIL overflow_sticky: error=%b words_written=%0d, required 1 2", error, words_written);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hCAFEF00D);
    wait_req_then_data();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_req, busy, done, error, rx_ready} !== 5'b0 ||
        bus_out !== 32'h0 || ctrl_out !== 8'h00 || words_written !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: req/busy/done/error/rx_ready=%b bus_out=%h ctrl_out=%h ww=%0d, required all 0",
               {bus_req, busy, done, error, rx_ready}, bus_out, ctrl_out, words_written);
    end
    reset   = 1'b0;
    bus_ack = 1'b0;
    test_single(32'h5A5AA5A5);
  endtask

  initial begin
    test_reset();
    test_single(32'h12345678);
    test_multi();
    test_zero_len();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
